// File: rtl/axis_udp_filter.sv
// Ethernet/IPv4/UDP receive filter on a 32-bit AXI4-Stream.
// Forwards only the byte-packed UDP payload of matching frames.
module axis_udp_filter #(
  parameter int          STREAM_DATA_WIDTH  = 32,
  parameter logic [47:0] MAC_ADDRESS        = 48'h00350a000201,
  parameter logic [31:0] IP_ADDRESS         = 32'h0a12a8c0,
  parameter logic [15:0] UDP_PORT           = 16'h901f,
  parameter int          PAYLOAD_MAX_SIZE   = 1600,
  parameter int          COUNTER_DATA_WIDTH = 11
) (
  input  logic                          clk_i,
  input  logic                          s_rst_n_i,
  input  logic [STREAM_DATA_WIDTH-1:0]  s_axis_tdata_i,
  input  logic [3:0]                    s_axis_tkeep_i,
  input  logic                          s_axis_tvalid_i,
  input  logic                          s_axis_tlast_i,
  output logic                          s_axis_tready_o,
  output logic [STREAM_DATA_WIDTH-1:0]  m_axis_tdata_o,
  output logic [3:0]                    m_axis_tkeep_o,
  output logic                          m_axis_tvalid_o,
  output logic                          m_axis_tlast_o,
  input  logic                          m_axis_tready_i,
  output logic                          counter_enable_o,
  output logic                          counter_rst_o,
  input  logic [COUNTER_DATA_WIDTH-1:0] counter_value_i
);

  localparam logic [1:0] S_HDR   = 2'd0;
  localparam logic [1:0] S_PAY   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [15:0] PMAX = 16'(PAYLOAD_MAX_SIZE);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        match_q, match_d;
  logic [15:0] plen_q, plen_d;
  logic [15:0] hold_q, hold_d;
  logic        seen_q, seen_d;
  logic        alive_q;
  logic        mv_q, mv_d;
  logic [31:0] md_q, md_d;
  logic [3:0]  mk_q, mk_d;
  logic        ml_q, ml_d;

  logic [31:0] d;
  logic        s_hs;
  logic        out_free;
  logic        hit;
  logic        match_now;
  logic [15:0] ulen;
  logic [15:0] ulen_m8;
  logic [15:0] rem;
  logic [3:0]  rem_keep;
  logic        cen;
  logic        crst;
  logic        rdy;
  logic        unused_tkeep;

  assign unused_tkeep = ^s_axis_tkeep_i;

  assign d        = s_axis_tdata_i;
  assign out_free = !mv_q || m_axis_tready_i;
  assign s_hs     = s_axis_tvalid_i && rdy;
  assign ulen     = {d[23:16], d[31:24]};
  assign ulen_m8  = ulen - 16'd8;
  assign rem      = plen_q - 16'(counter_value_i);

  always_comb begin
    hit = 1'b1;
    unique case (idx_q)
      4'd0:    hit = (d == MAC_ADDRESS[31:0]);
      4'd1:    hit = (d[15:0] == MAC_ADDRESS[47:32]);
      4'd3:    hit = (d[23:0] == 24'h450008);
      4'd5:    hit = (d[31:24] == 8'h11);
      4'd7:    hit = (d[31:16] == IP_ADDRESS[15:0]);
      4'd8:    hit = (d[15:0] == IP_ADDRESS[31:16]);
      4'd9:    hit = (d[15:0] == UDP_PORT) && (ulen >= 16'd8);
      default: hit = 1'b1;
    endcase
  end

  assign match_now = ((idx_q == 4'd0) || match_q) && hit;

  always_comb begin
    rem_keep = 4'h0;
    unique case (1'b1)
      (rem == 16'd1): rem_keep = 4'h1;
      (rem == 16'd2): rem_keep = 4'h3;
      (rem == 16'd3): rem_keep = 4'h7;
      (rem == 16'd4): rem_keep = 4'hF;
      default:        rem_keep = 4'h0;
    endcase
  end

  always_comb begin
    rdy = 1'b0;
    unique case (state_q)
      S_HDR:   rdy = alive_q;
      S_PAY:   rdy = out_free;
      S_FLUSH: rdy = 1'b0;
      S_DRAIN: rdy = alive_q;
      default: rdy = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    match_d = match_q;
    plen_d  = plen_q;
    hold_d  = hold_q;
    seen_d  = seen_q;
    mv_d    = mv_q && !m_axis_tready_i;
    md_d    = md_q;
    mk_d    = mk_q;
    ml_d    = ml_q;
    cen     = 1'b0;
    crst    = 1'b0;
    unique case (state_q)
      S_HDR: begin
        crst = 1'b1;
        if (s_hs) begin
          match_d = match_now;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd9) begin
            if (ulen < 16'd8)       plen_d = 16'd0;
            else if (ulen_m8 > PMAX) plen_d = PMAX;
            else                     plen_d = ulen_m8;
          end
          if (s_axis_tlast_i) begin
            idx_d = 4'd0;
          end else if (idx_q == 4'd10) begin
            idx_d  = 4'd0;
            hold_d = d[31:16];
            seen_d = 1'b0;
            if (!match_now)          state_d = S_DRAIN;
            else if (plen_q <= 16'd2) state_d = S_FLUSH;
            else                     state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (s_hs) begin
          mv_d   = 1'b1;
          md_d   = {d[15:0], hold_q};
          hold_d = d[31:16];
          if (rem <= 16'd4) begin
            mk_d    = rem_keep;
            ml_d    = 1'b1;
            state_d = s_axis_tlast_i ? S_HDR : S_DRAIN;
          end else if (s_axis_tlast_i) begin
            mk_d    = 4'hF;
            ml_d    = 1'b0;
            seen_d  = 1'b1;
            state_d = S_FLUSH;
          end else begin
            mk_d = 4'hF;
            ml_d = 1'b0;
            cen  = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          mv_d    = 1'b1;
          md_d    = {16'h0000, hold_q};
          mk_d    = 4'h3;
          ml_d    = 1'b1;
          state_d = seen_q ? S_HDR : S_DRAIN;
        end
      end
      S_DRAIN: begin
        crst = 1'b1;
        if (s_hs && s_axis_tlast_i) begin
          state_d = S_HDR;
          idx_d   = 4'd0;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk_i or negedge s_rst_n_i) begin
    if (!s_rst_n_i) begin
      state_q <= S_HDR;
      idx_q   <= 4'd0;
      match_q <= 1'b0;
      plen_q  <= 16'd0;
      hold_q  <= 16'd0;
      seen_q  <= 1'b0;
      alive_q <= 1'b0;
      mv_q    <= 1'b0;
      md_q    <= 32'd0;
      mk_q    <= 4'd0;
      ml_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      plen_q  <= plen_d;
      hold_q  <= hold_d;
      seen_q  <= seen_d;
      alive_q <= 1'b1;
      mv_q    <= mv_d;
      md_q    <= md_d;
      mk_q    <= mk_d;
      ml_q    <= ml_d;
    end
  end

  assign s_axis_tready_o  = rdy;
  assign m_axis_tvalid_o  = mv_q;
  assign m_axis_tdata_o   = md_q;
  assign m_axis_tkeep_o   = mk_q;
  assign m_axis_tlast_o   = ml_q;
  assign counter_enable_o = cen;
  assign counter_rst_o    = crst;

endmodule

// File: tb/tb_axis_udp_filter.sv
// Directed bench for axis_udp_filter with an external
// count-by-4 payload counter model.
module tb_axis_udp_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        c_en;
  logic        c_rst;
  logic [10:0] c_val = 11'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int to_cnt  = 0;
  int stall_viol = 0;
  bit tog = 1'b0;
  bit chk_stall = 1'b0;
  logic [36:0] q[$];

  always #5 clk = ~clk;

  axis_udp_filter dut (
    .clk_i            (clk),
    .s_rst_n_i        (rst_n),
    .s_axis_tdata_i   (s_data),
    .s_axis_tkeep_i   (s_keep),
    .s_axis_tvalid_i  (s_valid),
    .s_axis_tlast_i   (s_last),
    .s_axis_tready_o  (s_ready),
    .m_axis_tdata_o   (m_data),
    .m_axis_tkeep_o   (m_keep),
    .m_axis_tvalid_o  (m_valid),
    .m_axis_tlast_o   (m_last),
    .m_axis_tready_i  (m_ready),
    .counter_enable_o (c_en),
    .counter_rst_o    (c_rst),
    .counter_value_i  (c_val)
  );

  // External payload byte counter
  always @(posedge clk) begin
    if (c_rst) c_val <= 11'd0;
    else if (c_en && c_val <= 11'd1596) c_val <= c_val + 11'd4;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) q.push_back({m_last, m_keep, m_data});
      if (chk_stall && s_valid && s_ready && m_valid && !m_ready)
        stall_viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: still running, expected $finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) m_ready = ~m_ready;
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(string tag, int i, logic l,
                          logic [3:0] k, logic [31:0] dd);
    logic [63:0] got;
    got = 'x;
    if (q.size() > i) got = {27'd0, q[i]};
    chk(tag, got, {27'd0, l, k, dd});
  endtask

  task automatic send_beat(logic [31:0] dd, logic l, logic [3:0] k);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data  = dd;
    s_last  = l;
    s_keep  = k;
    do begin
      @(negedge clk);
      acc = s_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!acc) to_cnt++;
  endtask

  task automatic send_frame(logic [15:0] port, logic [15:0] ulen,
                            int npay, int padto, int maxb);
    byte unsigned b[$];
    logic [15:0] iplen;
    logic [31:0] dd;
    logic [3:0]  k;
    int nb;
    iplen = ulen + 16'd20;
    b = '{8'h01, 8'h02, 8'h00, 8'h0a, 8'h35, 8'h00,
          8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
          8'h08, 8'h00, 8'h45, 8'h00};
    b.push_back(iplen[15:8]);
    b.push_back(iplen[7:0]);
    b.push_back(8'h00); b.push_back(8'h00);
    b.push_back(8'h40); b.push_back(8'h00);
    b.push_back(8'h40); b.push_back(8'h11);
    b.push_back(8'h00); b.push_back(8'h00);
    b.push_back(8'hc0); b.push_back(8'ha8);
    b.push_back(8'h12); b.push_back(8'h01);
    b.push_back(8'hc0); b.push_back(8'ha8);
    b.push_back(8'h12); b.push_back(8'h0a);
    b.push_back(8'h12); b.push_back(8'h34);
    b.push_back(port[15:8]);
    b.push_back(port[7:0]);
    b.push_back(ulen[15:8]);
    b.push_back(ulen[7:0]);
    b.push_back(8'h00); b.push_back(8'h00);
    for (int i = 0; i < npay; i++) b.push_back(8'(i));
    while (b.size() < padto) b.push_back(8'h00);
    nb = (b.size() + 3) / 4;
    for (int i = 0; i < nb && i < maxb; i++) begin
      dd = 32'd0;
      k  = 4'd0;
      for (int j = 0; j < 4; j++) begin
        if (4 * i + j < b.size()) begin
          dd[8*j +: 8] = b[4*i+j];
          k[j] = 1'b1;
        end
      end
      send_beat(dd, i == nb - 1, k);
    end
  endtask

  task automatic chk_good12(string tag);
    chk({tag, "_n"}, q.size(), 3);
    chk_beat({tag, "_b0"}, 0, 1'b0, 4'hF, 32'h03020100);
    chk_beat({tag, "_b1"}, 1, 1'b0, 4'hF, 32'h07060504);
    chk_beat({tag, "_b2"}, 2, 1'b1, 4'hF, 32'h0B0A0908);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_mvalid"}, m_valid, 0);
    chk({tag, "_mdata"}, m_data, 0);
    chk({tag, "_mkeep"}, m_keep, 0);
    chk({tag, "_mlast"}, m_last, 0);
    chk({tag, "_sready"}, s_ready, 0);
    chk({tag, "_cen"}, c_en, 0);
    chk({tag, "_crst"}, c_rst, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_data  = 32'd0;
    s_keep  = 4'd0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();
    tick();

    send_frame(16'd8080, 16'd20, 12, 0, 99);
    repeat (10) tick();
    chk_good12("t1");
    q.delete();

    send_frame(16'd8081, 16'd20, 12, 0, 99);
    repeat (10) tick();
    chk("t2_drop_n", q.size(), 0);
    send_frame(16'd8080, 16'd20, 12, 0, 99);
    repeat (10) tick();
    chk_good12("t2_next");
    q.delete();

    send_frame(16'd8080, 16'd13, 5, 60, 99);
    repeat (10) tick();
    chk("t3_n", q.size(), 2);
    chk_beat("t3_b0", 0, 1'b0, 4'hF, 32'h03020100);
    chk_beat("t3_b1", 1, 1'b1, 4'h1, 32'h00000004);
    q.delete();

    stall_viol = 0;
    tog = 1'b1;
    chk_stall = 1'b1;
    send_frame(16'd8080, 16'd20, 12, 0, 99);
    repeat (20) tick();
    tog = 1'b0;
    chk_stall = 1'b0;
    m_ready = 1'b1;
    repeat (4) tick();
    chk_good12("t4");
    chk("t4_stall_accept", stall_viol, 0);
    q.delete();

    send_frame(16'd8080, 16'd40, 10, 0, 99);
    repeat (10) tick();
    chk("t5_n", q.size(), 3);
    chk_beat("t5_b0", 0, 1'b0, 4'hF, 32'h03020100);
    chk_beat("t5_b1", 1, 1'b0, 4'hF, 32'h07060504);
    chk_beat("t5_b2", 2, 1'b1, 4'h3, 32'h00000908);
    q.delete();

    m_ready = 1'b0;
    send_frame(16'd8080, 16'd20, 12, 0, 12);
    tick();
    chk("t6_pending", {m_valid, m_data}, {1'b1, 32'h03020100});
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t6_rst");
    tick();
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    q.delete();
    tick();
    tick();
    send_frame(16'd8080, 16'd20, 12, 0, 99);
    repeat (10) tick();
    chk_good12("t6_after");

    chk("beat_accept_timeouts", to_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
